// File: rtl/amba_apb_slave_mem_if.sv
// APB bus bundle between a requester and the register-file completer.
// The master modport drives the request; the slave modport answers it.
interface amba_apb_slave_mem_if #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/amba_apb_slave_mem.sv
// APB completer backed by a DEPTH-entry register file.
// Transfers complete after WAIT_STATES stalled ACCESS cycles; out-of-range addresses raise pslverr.
module amba_apb_slave_mem #(
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned DEPTH       = 128,
   parameter int unsigned WAIT_STATES = 0
) (
   input logic                  pclk,
   input logic                  preset,
   amba_apb_slave_mem_if.slave  bus
);

   localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DepthL = (ADDR_WIDTH + 1)'(DEPTH);

   typedef enum logic [0:0] {StIdle, StAccess} state_e;

   state_e                state_q, state_d;
   logic [3:0]            wcnt_q, wcnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  write_q, write_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  mem_we;
   logic                  setup_err;
   logic                  pready;

   assign setup_err = ({1'b0, bus.paddr} >= DepthL);

   // Completion is decoded from registered state but gated live by the strobes,
   // so an abort cycle never shows pready.
   assign pready      = (state_q == StAccess) && (wcnt_q == 4'd0) && bus.psel && bus.penable;
   assign bus.pready  = pready;
   assign bus.pslverr = pready && err_q;
   assign bus.prdata  = prdata_q;

   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      addr_d   = addr_q;
      write_d  = write_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      prdata_d = prdata_q;
      mem_we   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.psel && !bus.penable) begin
               state_d = StAccess;
               addr_d  = bus.paddr;
               write_d = bus.pwrite;
               wdata_d = bus.pwdata;
               err_d   = setup_err;
               wcnt_d  = 4'(WAIT_STATES);
               if (!bus.pwrite) begin
                  prdata_d = setup_err ? '0 : mem_q[bus.paddr[IdxW-1:0]];
               end
            end
         end
         StAccess: begin
            if (bus.psel && bus.penable) begin
               if (wcnt_q != 4'd0) begin
                  wcnt_d = wcnt_q - 4'd1;
               end else begin
                  state_d = StIdle;
                  mem_we  = write_q && !err_q;
               end
            end else begin
               state_d = StIdle;
               wcnt_d  = 4'd0;
            end
         end
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q  <= StIdle;
         wcnt_q   <= 4'd0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
         prdata_q <= '0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
         prdata_q <= prdata_d;
      end
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_we) begin
         mem_q[addr_q[IdxW-1:0]] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_amba_apb_slave_mem.sv
// Randomised APB bench: the driver pushes expected completions into a queue,
// a negedge monitor pops and compares whenever the completer raises pready.
module tb_amba_apb_slave_mem;

   localparam int unsigned DEPTH = 128;
   localparam int unsigned WAITS = 2;

   typedef struct {
      logic [7:0] data;
      logic       err;
   } exp_t;

   logic pclk;
   logic preset;
   int   tests;
   int   fails;
   exp_t exp_q[$];
   logic [7:0] model [DEPTH];
   logic [7:0] last_rd;

   amba_apb_slave_mem_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

   amba_apb_slave_mem #(
      .ADDR_WIDTH (8),
      .DATA_WIDTH (8),
      .DEPTH      (DEPTH),
      .WAIT_STATES(WAITS)
   ) dut (
      .pclk  (pclk),
      .preset(preset),
      .bus   (bus)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every pready must match the oldest outstanding expectation.
   always @(negedge pclk) begin
      if (!preset && bus.pready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected pready", 32'(bus.pready), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("pslverr", 32'(bus.pslverr), 32'(e.err));
            check("prdata", 32'(bus.prdata), 32'(e.data));
         end
      end
   end

   function automatic void push_exp(input bit wr, input logic [7:0] a, input logic [7:0] d);
      exp_t e;
      e.err = (a >= 8'(DEPTH));
      if (wr) begin
         if (!e.err) model[a[6:0]] = d;
      end else begin
         last_rd = e.err ? 8'h00 : model[a[6:0]];
      end
      e.data = last_rd;  // writes leave prdata at the last read value
      exp_q.push_back(e);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < int'(DEPTH); i++) model[i] = 8'h00;
      last_rd = 8'h00;
   endfunction

   task automatic bus_idle(input int n);
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
      repeat (n) begin
         @(posedge pclk);
         #1;
      end
   endtask

   // Full transfer; returns just after the completion edge with the strobes still high.
   task automatic xfer(input bit wr, input logic [7:0] a, input logic [7:0] d);
      int   cycles;
      logic rdy;
      bus.psel    = 1'b1;
      bus.penable = 1'b0;
      bus.pwrite  = wr;
      bus.paddr   = a;
      bus.pwdata  = d;
      push_exp(wr, a, d);
      @(posedge pclk);
      #1;
      bus.penable = 1'b1;
      // Bus changes during ACCESS must be ignored by the completer.
      bus.paddr   = 8'($urandom);
      bus.pwdata  = 8'($urandom);
      bus.pwrite  = 1'($urandom);
      cycles = 0;
      do begin
         @(negedge pclk);
         cycles++;
         rdy = bus.pready;
      end while (!rdy && cycles < int'(WAITS) + 4);
      check("access cycles", 32'(cycles), 32'(WAITS + 1));
      @(posedge pclk);
      #1;
   endtask

   task automatic abort_xfer(input bit wr, input logic [7:0] a, input logic [7:0] d);
      bus.psel    = 1'b1;
      bus.penable = 1'b0;
      bus.pwrite  = wr;
      bus.paddr   = a;
      bus.pwdata  = d;
      if (!wr) last_rd = (a >= 8'(DEPTH)) ? 8'h00 : model[a[6:0]];
      @(posedge pclk);
      #1;
      bus.psel    = 1'b0;
      bus.penable = 1'b1;
      @(negedge pclk);
      check("abort pready", 32'(bus.pready), 32'd0);
      @(posedge pclk);
      #1;
      bus.penable = 1'b0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
      bus.pwrite  = 1'b0;
      bus.paddr   = '0;
      bus.pwdata  = '0;
      preset      = 1'b1;
      model_reset();
      repeat (2) @(posedge pclk);
      #1;
      preset = 1'b0;
      @(negedge pclk);
      check("reset prdata", 32'(bus.prdata), 32'h00);
      check("reset pready", 32'(bus.pready), 32'd0);
      check("reset pslverr", 32'(bus.pslverr), 32'd0);
      @(posedge pclk);
      #1;

      xfer(1'b0, 8'h05, 8'h00);
      xfer(1'b1, 8'h10, 8'hA5);
      xfer(1'b0, 8'h10, 8'h00);
      xfer(1'b1, 8'h7F, 8'h3C);
      xfer(1'b0, 8'h7F, 8'h00);
      bus_idle(1);

      // Out of range: write dropped, read returns zero, entry 0 untouched.
      xfer(1'b1, 8'h00, 8'h66);
      xfer(1'b1, 8'h80, 8'hFF);
      xfer(1'b0, 8'h80, 8'h00);
      xfer(1'b0, 8'h00, 8'h00);
      bus_idle(1);

      xfer(1'b1, 8'h20, 8'h5A);
      bus_idle(1);
      abort_xfer(1'b1, 8'h20, 8'h11);
      xfer(1'b0, 8'h20, 8'h00);

      xfer(1'b1, 8'h01, 8'hC1);
      xfer(1'b1, 8'h02, 8'hC2);
      xfer(1'b1, 8'h03, 8'hC3);
      xfer(1'b0, 8'h01, 8'h00);
      xfer(1'b0, 8'h02, 8'h00);
      xfer(1'b0, 8'h03, 8'h00);
      bus_idle(1);

      // Illegal strobe from IDLE: no response, no storage change.
      bus.psel    = 1'b1;
      bus.penable = 1'b1;
      bus.pwrite  = 1'b1;
      bus.paddr   = 8'h01;
      bus.pwdata  = 8'hEE;
      repeat (2) begin
         @(negedge pclk);
         check("illegal pready", 32'(bus.pready), 32'd0);
         @(posedge pclk);
         #1;
      end
      bus_idle(1);
      xfer(1'b0, 8'h01, 8'h00);
      bus_idle(1);

      // Reset mid-read of a non-zero entry.
      bus.psel    = 1'b1;
      bus.penable = 1'b0;
      bus.pwrite  = 1'b0;
      bus.paddr   = 8'h03;
      @(posedge pclk);
      #1;
      check("prdata before reset", 32'(bus.prdata), 32'hC3);
      bus.penable = 1'b1;
      preset      = 1'b1;
      @(posedge pclk);
      #1;
      @(negedge pclk);
      check("reset mid-read pready", 32'(bus.pready), 32'd0);
      check("reset mid-read prdata", 32'(bus.prdata), 32'h00);
      #1;
      preset = 1'b0;
      model_reset();
      bus_idle(1);
      xfer(1'b0, 8'h03, 8'h00);
      bus_idle(1);

      for (int i = 0; i < 120; i++) begin
         logic [7:0] a;
         logic [7:0] d;
         bit         wr;
         a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
         d  = 8'($urandom);
         wr = 1'($urandom);
         if ($urandom_range(0, 9) == 0) abort_xfer(wr, a, d);
         else xfer(wr, a, d);
         if ($urandom_range(0, 2) == 0) bus_idle(int'($urandom_range(1, 2)));
      end

      bus_idle(3);
      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
